// File: rtl/superscalar_instr_queue.sv
// Multi-lane circular instruction queue: up to WR_PORTS pushes and RD_PORTS pops per cycle.
// Writes and reads are each accepted as a leading prefix of lanes. Slot indices wrap
// modulo DEPTH, and DEPTH does not have to be a power of two.
// Optional protocol checker: define SUPERSCALAR_IQ_ERR_CHECK_EN to enable the sticky err_o.
// With the macro undefined, err_o is tied to 0.
module superscalar_instr_queue #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned WR_PORTS = 2,
  parameter int unsigned RD_PORTS = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          flush_i,
  input  logic [WR_PORTS-1:0]           wr_valid_i,
  input  logic [WR_PORTS*DATA_W-1:0]    wr_data_i,
  output logic [WR_PORTS-1:0]           wr_ready_o,
  output logic [RD_PORTS-1:0]           rd_valid_o,
  output logic [RD_PORTS*DATA_W-1:0]    rd_data_o,
  input  logic [RD_PORTS-1:0]           rd_ready_i,
  output logic [$clog2(DEPTH+1)-1:0]    count_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic                          err_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  // Wide enough to hold base + offset < 2*DEPTH before the modulo fold
  localparam int unsigned SUM_W = CNT_W + 1;

  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [CNT_W-1:0]  free_slots;
  logic [WR_PORTS-1:0] wr_en;
  logic [RD_PORTS-1:0] rd_en;
  logic [CNT_W-1:0]  acc_cnt;
  logic [CNT_W-1:0]  pop_cnt;
  logic [PTR_W-1:0]  wr_idx [WR_PORTS];
  logic [PTR_W-1:0]  rd_idx [RD_PORTS];

  // (base + off) mod DEPTH; both operands are below DEPTH, so a single fold suffices
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                input logic [CNT_W-1:0] off);
    logic [SUM_W-1:0] s;
    s = SUM_W'(base) + SUM_W'(off);
    if (s >= SUM_W'(DEPTH)) s = s - SUM_W'(DEPTH);
    return PTR_W'(s);
  endfunction

  assign free_slots = CNT_W'(DEPTH) - count;

  // Write-lane readiness comes from registered occupancy only; same-cycle pops free nothing
  always_comb begin
    wr_ready_o = '0;
    for (int i = 0; i < WR_PORTS; i++) begin
      wr_ready_o[i] = (CNT_W'(i) < free_slots);
    end
  end

  // Accept the leading prefix of valid and ready write lanes; flush blocks all writes
  always_comb begin
    logic run;
    run     = ~flush_i;
    wr_en   = '0;
    acc_cnt = '0;
    for (int i = 0; i < WR_PORTS; i++) begin
      run      = run & wr_valid_i[i] & wr_ready_o[i];
      wr_en[i] = run;
      if (run) acc_cnt = acc_cnt + CNT_W'(1);
    end
  end

  // Write slot for each lane, relative to tail
  always_comb begin
    for (int i = 0; i < WR_PORTS; i++) begin
      wr_idx[i] = wrap_add(tail, CNT_W'(i));
    end
  end

  // Read lanes present the oldest entries, starting at head on lane 0
  always_comb begin
    rd_valid_o = '0;
    rd_data_o  = '0;
    for (int i = 0; i < RD_PORTS; i++) begin
      rd_idx[i]                        = wrap_add(head, CNT_W'(i));
      rd_valid_o[i]                    = (CNT_W'(i) < count);
      rd_data_o[i*DATA_W +: DATA_W]    = mem[rd_idx[i]];
    end
  end

  // Pop the leading prefix of valid and ready read lanes; flush blocks all pops
  always_comb begin
    logic run;
    run     = ~flush_i;
    rd_en   = '0;
    pop_cnt = '0;
    for (int i = 0; i < RD_PORTS; i++) begin
      run      = run & rd_valid_o[i] & rd_ready_i[i];
      rd_en[i] = run;
      if (run) pop_cnt = pop_cnt + CNT_W'(1);
    end
  end

  // Pointer and occupancy state; flush discards every entry
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= wrap_add(head, pop_cnt);
      tail  <= wrap_add(tail, acc_cnt);
      count <= count + acc_cnt - pop_cnt;
    end
  end

  // Payload storage is intentionally not reset
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < WR_PORTS; i++) begin
      if (wr_en[i]) mem[wr_idx[i]] <= wr_data_i[i*DATA_W +: DATA_W];
    end
  end

  // Status flags derived from the occupancy register
  always_comb begin
    count_o = count;
    full_o  = (count == CNT_W'(DEPTH));
    empty_o = (count == '0);
  end

`ifdef SUPERSCALAR_IQ_ERR_CHECK_EN
  logic err_q;
  logic err_hit;

  // Protocol violations: lane gaps on either side, or reading a lane with no entry
  always_comb begin
    err_hit = 1'b0;
    for (int i = 1; i < WR_PORTS; i++) begin
      err_hit = err_hit | (wr_valid_i[i] & ~wr_valid_i[i-1]);
    end
    for (int i = 1; i < RD_PORTS; i++) begin
      err_hit = err_hit | (rd_ready_i[i] & ~rd_ready_i[i-1]);
    end
    for (int i = 0; i < RD_PORTS; i++) begin
      err_hit = err_hit | (rd_ready_i[i] & ~rd_valid_o[i]);
    end
  end

  // Sticky error flag, cleared only by reset or flush
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else if (flush_i) begin
      err_q <= 1'b0;
    end else if (err_hit) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  // Per-lane enables are consumed by the loops above; reduce them to keep them referenced
  logic unused_en;
  assign unused_en = ^{wr_en, rd_en};

endmodule

// File: tb/tb_superscalar_instr_queue.sv
// Directed bench for superscalar_instr_queue.
// One DEPTH=8 instance with 2 write and 2 read lanes, and one DEPTH=6 instance for wrap ordering.
module tb_superscalar_instr_queue;

  logic clk;
  logic rst;

  // DEPTH = 8 instance
  logic         flush8;
  logic [1:0]   wr_valid8;
  logic [127:0] wr_data8;
  logic [1:0]   wr_ready8;
  logic [1:0]   rd_valid8;
  logic [127:0] rd_data8;
  logic [1:0]   rd_ready8;
  logic [3:0]   count8;
  logic         full8;
  logic         empty8;
  logic         err8;

  // DEPTH = 6 instance
  logic         flush6;
  logic [1:0]   wr_valid6;
  logic [31:0]  wr_data6;
  logic [1:0]   wr_ready6;
  logic [1:0]   rd_valid6;
  logic [31:0]  rd_data6;
  logic [1:0]   rd_ready6;
  logic [2:0]   count6;
  logic         full6;
  logic         empty6;
  logic         err6;

  int checks;
  int errors;

  superscalar_instr_queue #(.DEPTH(8), .DATA_W(64), .WR_PORTS(2), .RD_PORTS(2)) u8 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush8),
    .wr_valid_i(wr_valid8), .wr_data_i(wr_data8), .wr_ready_o(wr_ready8),
    .rd_valid_o(rd_valid8), .rd_data_o(rd_data8), .rd_ready_i(rd_ready8),
    .count_o(count8), .full_o(full8), .empty_o(empty8), .err_o(err8)
  );

  superscalar_instr_queue #(.DEPTH(6), .DATA_W(16), .WR_PORTS(2), .RD_PORTS(2)) u6 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush6),
    .wr_valid_i(wr_valid6), .wr_data_i(wr_data6), .wr_ready_o(wr_ready6),
    .rd_valid_o(rd_valid6), .rd_data_o(rd_data6), .rd_ready_i(rd_ready6),
    .count_o(count6), .full_o(full6), .empty_o(empty6), .err_o(err6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle past it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle8();
    flush8 = 1'b0; wr_valid8 = 2'b00; rd_ready8 = 2'b00; wr_data8 = '0;
  endtask

  task automatic idle6();
    flush6 = 1'b0; wr_valid6 = 2'b00; rd_ready6 = 2'b00; wr_data6 = '0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    idle8();
    idle6();
    tick();
    tick();

    // Reset state
    chk("rst_count", 64'(count8), 64'd0);
    chk("rst_empty", 64'(empty8), 64'd1);
    chk("rst_full", 64'(full8), 64'd0);
    chk("rst_wr_ready", 64'(wr_ready8), 64'b11);
    chk("rst_rd_valid", 64'(rd_valid8), 64'b00);
    chk("rst_err", 64'(err8), 64'd0);
    chk("rst_count6", 64'(count6), 64'd0);
    rst = 1'b0;
    tick();

    // Two-lane write becomes visible the next cycle, not before
    wr_valid8 = 2'b11; wr_data8 = {64'h101, 64'h100};
    chk("no_bypass_rd_valid", 64'(rd_valid8), 64'b00);
    tick();
    idle8();
    chk("wr2_count", 64'(count8), 64'd2);
    chk("wr2_rd_valid", 64'(rd_valid8), 64'b11);
    chk("wr2_data0", rd_data8[63:0], 64'h100);
    chk("wr2_data1", rd_data8[127:64], 64'h101);

    // Fill to 7 entries
    wr_valid8 = 2'b11; wr_data8 = {64'h103, 64'h102}; tick();
    wr_valid8 = 2'b11; wr_data8 = {64'h105, 64'h104}; tick();
    wr_valid8 = 2'b01; wr_data8 = {64'h0,   64'h106}; tick();
    idle8();
    chk("c7_count", 64'(count8), 64'd7);
    chk("c7_wr_ready", 64'(wr_ready8), 64'b01);

    // Only lane 0 fits when one slot remains
    wr_valid8 = 2'b11; wr_data8 = {64'h108, 64'h107}; tick();
    idle8();
    chk("c8_count", 64'(count8), 64'd8);
    chk("c8_full", 64'(full8), 64'd1);
    chk("c8_wr_ready", 64'(wr_ready8), 64'b00);
    chk("c8_data0", rd_data8[63:0], 64'h100);

    // Full queue: pop two while both write lanes request; nothing is accepted
    rd_ready8 = 2'b11; wr_valid8 = 2'b11; wr_data8 = {64'h1F1, 64'h1F0}; tick();
    idle8();
    chk("pop2_count", 64'(count8), 64'd6);
    chk("pop2_full", 64'(full8), 64'd0);
    chk("pop2_data0", rd_data8[63:0], 64'h102);
    chk("pop2_data1", rd_data8[127:64], 64'h103);

    // Single pop with a single write in the same cycle
    rd_ready8 = 2'b01; wr_valid8 = 2'b01; wr_data8 = {64'h0, 64'h109}; tick();
    idle8();
    chk("mix_count", 64'(count8), 64'd6);
    chk("mix_data0", rd_data8[63:0], 64'h103);
    chk("mix_data1", rd_data8[127:64], 64'h104);

    // Drop to 5 entries, then flush with writes and reads pending
    rd_ready8 = 2'b01; tick();
    idle8();
    chk("c5_count", 64'(count8), 64'd5);
    chk("c5_data0", rd_data8[63:0], 64'h104);
    flush8 = 1'b1; wr_valid8 = 2'b11; rd_ready8 = 2'b11; wr_data8 = {64'h2F1, 64'h2F0}; tick();
    idle8();
    chk("flush_count", 64'(count8), 64'd0);
    chk("flush_empty", 64'(empty8), 64'd1);
    chk("flush_rd_valid", 64'(rd_valid8), 64'b00);
    chk("flush_wr_ready", 64'(wr_ready8), 64'b11);

    // Pointers restart at zero after flush
    wr_valid8 = 2'b01; wr_data8 = {64'h0, 64'h200}; tick();
    idle8();
    chk("post_flush_count", 64'(count8), 64'd1);
    chk("post_flush_data0", rd_data8[63:0], 64'h200);
    rd_ready8 = 2'b01; tick();
    idle8();
    chk("post_flush_empty", 64'(empty8), 64'd1);

    // Reading an empty queue pops nothing and trips the checker when enabled
    rd_ready8 = 2'b01; tick();
    idle8();
    chk("rd_empty_count", 64'(count8), 64'd0);
`ifdef SUPERSCALAR_IQ_ERR_CHECK_EN
    chk("err_set", 64'(err8), 64'd1);
    tick();
    chk("err_held", 64'(err8), 64'd1);
`else
    chk("err_tied", 64'(err8), 64'd0);
    tick();
    chk("err_tied_held", 64'(err8), 64'd0);
`endif
    flush8 = 1'b1; tick();
    idle8();
    chk("err_cleared", 64'(err8), 64'd0);

    // Asynchronous reset in mid-operation discards entries without waiting for an edge
    wr_valid8 = 2'b11; wr_data8 = {64'h301, 64'h300}; tick();
    idle8();
    chk("pre_rst_count", 64'(count8), 64'd2);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_count", 64'(count8), 64'd0);
    chk("async_rst_rd_valid", 64'(rd_valid8), 64'b00);
    tick();
    rst = 1'b0;
    tick();
    chk("after_rst_empty", 64'(empty8), 64'd1);

    // DEPTH=6: push 1..6, pop 1..4, push 7..10, drain; order must survive the wrap
    wr_valid6 = 2'b11; wr_data6 = {16'd2, 16'd1}; tick();
    wr_valid6 = 2'b11; wr_data6 = {16'd4, 16'd3}; tick();
    wr_valid6 = 2'b11; wr_data6 = {16'd6, 16'd5}; tick();
    idle6();
    chk("d6_full", 64'(full6), 64'd1);
    chk("d6_count6", 64'(count6), 64'd6);
    chk("d6_wr_ready_full", 64'(wr_ready6), 64'b00);
    chk("d6_pop_a0", 64'(rd_data6[15:0]), 64'd1);
    chk("d6_pop_a1", 64'(rd_data6[31:16]), 64'd2);
    rd_ready6 = 2'b11; tick();
    idle6();
    chk("d6_pop_b0", 64'(rd_data6[15:0]), 64'd3);
    chk("d6_pop_b1", 64'(rd_data6[31:16]), 64'd4);
    rd_ready6 = 2'b11; tick();
    idle6();
    chk("d6_count2", 64'(count6), 64'd2);
    wr_valid6 = 2'b11; wr_data6 = {16'd8, 16'd7}; tick();
    wr_valid6 = 2'b11; wr_data6 = {16'd10, 16'd9}; tick();
    idle6();
    chk("d6_refill_count", 64'(count6), 64'd6);
    chk("d6_pop_c0", 64'(rd_data6[15:0]), 64'd5);
    rd_ready6 = 2'b01; tick();
    idle6();
    chk("d6_wrap_lane0", 64'(rd_data6[15:0]), 64'd6);
    chk("d6_wrap_lane1", 64'(rd_data6[31:16]), 64'd7);
    rd_ready6 = 2'b11; tick();
    idle6();
    chk("d6_pop_e0", 64'(rd_data6[15:0]), 64'd8);
    chk("d6_pop_e1", 64'(rd_data6[31:16]), 64'd9);
    rd_ready6 = 2'b11; tick();
    idle6();
    chk("d6_pop_f0", 64'(rd_data6[15:0]), 64'd10);
    chk("d6_last_count", 64'(count6), 64'd1);
    rd_ready6 = 2'b01; tick();
    idle6();
    chk("d6_drained", 64'(empty6), 64'd1);
    chk("d6_err", 64'(err6), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
